sb_tx_serializer: RTL and testbench
===================================

# sb_tx_serializer

Bit-serialises the 10-bit framed sideband symbols produced by the transactions generator FSM onto the single-wire SBTX line. Computes the transaction CRC-16 on the fly over payload bytes and substitutes it into the two CRC symbol slots. Sits directly downstream of the transactions generator and drives the SBTX pad logic.

## Interface
- No parameters. Symbol width (10) and CRC constants are fixed and come from the shared package.
- sb_clk  in  1  sideband clock; same clock as the transactions generator.
- rst  in  1  asynchronous, active-high reset.
- trans  in  10  framed symbol {stop, byte[7:0], start}; held stable for 10 cycles per symbol.
- trans_state  in  2  0 = disconnected, 1 = idle, 2 = transaction in progress (START).
- crc_en  in  1  the symbol being loaded is CRC-covered payload.
- sbtx_sel  in  1  the symbol being loaded is a CRC slot; its byte content is replaced.
- disconnected_s  in  1  generator is in its DISCONNECT state.
- sbtx  out  1  serial SBTX line.
- tx_busy  out  1  a symbol is being shifted.
- crc_out  out  16  final CRC value. Exists only with SB_TX_CRC_OUT_EN.
- crc_valid  out  1  one-cycle pulse when crc_out updates. Exists only with SB_TX_CRC_OUT_EN.

## Operation
- Line states (registered sbtx):
  - disconnected_s=1 or trans_state=0 with no symbol in flight: sbtx=0.
  - trans_state=1 with no symbol in flight: sbtx=1.
- bit_cnt (4-bit) counts 0..9 and wraps.
  - A load occurs when bit_cnt=0 and trans_state=2.
  - On a load, shift_reg ← symbol and bit_cnt → 1.
  - bit_cnt keeps advancing until it wraps to 0, even if trans_state leaves 2 mid-symbol. The last symbol (ETX) always completes.
- Load content:
  - sbtx_sel=0: symbol = trans.
  - sbtx_sel=1, first CRC slot: symbol = {1, crc_reg[15:8], 0}.
  - sbtx_sel=1, second CRC slot: symbol = {1, crc_reg[7:0], 0}.
  - crc_slot flag: cleared at transaction start, toggles on every sbtx_sel load.
- Bit order: shift_reg is sent LSB first (start bit 0, data LSB..MSB, stop bit 1).
- CRC state machine, states INIT / ACCUM / HOLD:
  - INIT: crc_reg=16'hFFFF. Entered whenever trans_state≠2.
  - ACCUM: entered on a load with crc_en=1 and sbtx_sel=0. Each data bit d (bits 1..8 of the symbol, in send order) updates the register: fb=d^crc[15]; crc ← {crc[14:0],0} ^ (fb ? 16'h8005 : 0).
  - HOLD: entered on the first sbtx_sel load. The CRC is frozen until the next INIT.
  - Start/stop bits and symbols loaded with crc_en=0 never update the CRC.
- disconnected_s=1 aborts immediately:
  - at the next edge: bit_cnt=0, shift_reg cleared, crc_reg=FFFF, crc_slot=0, sbtx=0, tx_busy=0.
  - it overrides any in-flight symbol.

## Timing
- Reset values: sbtx=0, tx_busy=0, bit_cnt=0, shift_reg=0, crc_reg=16'hFFFF, crc_slot=0, crc_out=0, crc_valid=0.
- Load at edge k drives bit i on sbtx during cycles k+1+i, for i=0..9. Latency from trans to the first bit is 1 cycle.
- Symbol period is exactly 10 cycles. This matches the generator's 10-cycle hold, so consecutive loads occur every 10 cycles with no gap.
- tx_busy=1 from the cycle after a load through the cycle the stop bit is driven.
- The CRC is final one cycle before the next load: the last data bit updates at bit_cnt=8.
- crc_valid pulses in the cycle after the first sbtx_sel load. crc_out holds until the next pulse or reset.
- rst asserted mid-symbol: all state returns to reset values asynchronously, and the partial symbol is dropped.
- Simultaneous disconnected_s=1 and a load: disconnect wins and no load occurs.

## Configuration
- SB_TX_CRC_OUT_EN defined: crc_out and crc_valid ports plus their registers exist, for debug and the scoreboard.
- Undefined: the ports are absent. sbtx behaviour is identical in both builds.

## Structure
- Package sb_tx_pkg holds:
  - SB_SYM_W=10, SB_CRC_POLY=16'h8005, SB_CRC_INIT=16'hFFFF;
  - trans_state encodings DISCONNECTED_S/IDLE_S/START;
  - the CRC state enum.
- Sub-module sb_crc16_serial: 1-bit CRC update with init, enable and hold inputs. The serializer instantiates it once.

## Test plan
- Reset and link states:
  - assert rst → sbtx=0, tx_busy=0;
  - trans_state=1 → sbtx=1 on the next edge.
- Single DLE symbol {1,8'hFE,0} with trans_state=2 → sbtx = 0,0,1,1,1,1,1,1,1,1 over cycles k+1..k+10; tx_busy high for exactly those 10 cycles.
- CRC check:
  - sequence: DLE (crc_en=0), payload {1,8'h00,0} (crc_en=1), then two sbtx_sel=1 symbols;
  - expected: CRC symbols carry 8'hFD then 8'h02 (bits LSB first);
  - with SB_TX_CRC_OUT_EN: crc_out=16'hFD02 and crc_valid pulses once.
- Back-to-back transactions: run the CRC scenario twice with one idle gap → identical CRC bytes both times (CRC re-inits in idle).
- Abort on disconnect: assert disconnected_s at bit_cnt=5 of a payload symbol → sbtx=0 at the next edge, bit_cnt=0; the next transaction starts cleanly with crc=FFFF.
- Async reset mid-CRC-slot: assert rst while the first CRC symbol is shifting → all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/sb_tx_serializer_pkg.sv
// Shared types and constants for the sideband TX serializer: symbol framing,
// CRC-16 constants, link-state encodings and the CRC state enum.
package sb_tx_pkg;

  localparam int unsigned SB_SYM_W  = 10;
  localparam int unsigned SB_DATA_W = 8;
  localparam int unsigned SB_CRC_W  = 16;
  localparam int unsigned SB_CNT_W  = 4;

  localparam logic [SB_CRC_W-1:0] SB_CRC_POLY = 16'h8005;
  localparam logic [SB_CRC_W-1:0] SB_CRC_INIT = 16'hFFFF;

  localparam logic [SB_CNT_W-1:0] SB_LAST_BIT      = SB_CNT_W'(9);
  localparam logic [SB_CNT_W-1:0] SB_LAST_DATA_BIT = SB_CNT_W'(8);

  typedef enum logic [1:0] {
    DISCONNECTED_S = 2'd0,
    IDLE_S         = 2'd1,
    START          = 2'd2
  } trans_state_e;

  typedef enum logic [1:0] {
    CRC_INIT  = 2'd0,
    CRC_ACCUM = 2'd1,
    CRC_HOLD  = 2'd2
  } crc_state_e;

  // Framed sideband symbol, sent LSB (start bit) first.
  typedef struct packed {
    logic                 stop;
    logic [SB_DATA_W-1:0] data;
    logic                 start;
  } sb_sym_t;

  // Framed CRC slot symbol carrying either the high or the low CRC byte.
  function automatic sb_sym_t crc_slot_sym(input logic [SB_CRC_W-1:0] crc,
                                           input logic                low_byte);
    sb_sym_t s;
    s.stop  = 1'b1;
    s.start = 1'b0;
    s.data  = low_byte ? crc[SB_DATA_W-1:0] : crc[SB_CRC_W-1:SB_DATA_W];
    return s;
  endfunction

endpackage

// File: rtl/sb_tx_serializer_if.sv
// Generator-to-serializer sideband bus. crc_out/crc_valid exist only when
// SB_TX_CRC_OUT_EN is defined.
interface sb_tx_serializer_if;
  import sb_tx_pkg::*;

  sb_sym_t                trans;
  trans_state_e           trans_state;
  logic                   crc_en;
  logic                   sbtx_sel;
  logic                   disconnected_s;
  logic                   sbtx;
  logic                   tx_busy;
`ifdef SB_TX_CRC_OUT_EN
  logic [SB_CRC_W-1:0]    crc_out;
  logic                   crc_valid;
`endif

  modport master (
    output trans, trans_state, crc_en, sbtx_sel, disconnected_s,
`ifdef SB_TX_CRC_OUT_EN
    input  crc_out, crc_valid,
`endif
    input  sbtx, tx_busy
  );

  modport slave (
    input  trans, trans_state, crc_en, sbtx_sel, disconnected_s,
`ifdef SB_TX_CRC_OUT_EN
    output crc_out, crc_valid,
`endif
    output sbtx, tx_busy
  );

endinterface

// File: rtl/sb_tx_serializer_crc16.sv
// Bit-serial CRC-16 register: one data bit per enabled cycle, synchronous
// re-init (highest priority) and a hold input that freezes the value.
module sb_crc16_serial
  import sb_tx_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                en,
  input  logic                hold,
  input  logic                d,
  output logic [SB_CRC_W-1:0] crc
);

  logic [SB_CRC_W-1:0] crc_q;
  logic [SB_CRC_W-1:0] crc_d;
  logic                fb_c;

  always_comb begin
    crc_d = crc_q;
    fb_c  = d ^ crc_q[SB_CRC_W-1];
    if (init) begin
      crc_d = SB_CRC_INIT;
    end else if (en && !hold) begin
      crc_d = {crc_q[SB_CRC_W-2:0], 1'b0} ^ (fb_c ? SB_CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= SB_CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sb_tx_serializer.sv
// Serialises framed sideband symbols onto SBTX, substituting an on-the-fly
// CRC-16 into the CRC slots. Optional debug ports: SB_TX_CRC_OUT_EN.
module sb_tx_serializer
  import sb_tx_pkg::*;
(
  input logic               sb_clk,
  input logic               rst,
  sb_tx_serializer_if.slave bus
);

  logic [SB_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [SB_SYM_W-1:0] shift_reg_q, shift_reg_d;
  logic                sbtx_q,      sbtx_d;
  logic                tx_busy_q,   tx_busy_d;
  logic                crc_slot_q,  crc_slot_d;
  logic                sym_crc_q,   sym_crc_d;
  crc_state_e          crc_state_q, crc_state_d;

  logic                load_c;
  sb_sym_t             load_sym_c;
  logic [SB_CRC_W-1:0] crc_c;
  logic                crc_init_c;
  logic                crc_hold_c;
  logic                crc_upd_c;
  logic                crc_bit_c;

  // Load decision, CRC control and the bit-slot sequencing.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    sbtx_d      = sbtx_q;
    tx_busy_d   = tx_busy_q;
    crc_slot_d  = crc_slot_q;
    sym_crc_d   = sym_crc_q;
    crc_state_d = crc_state_q;

    load_c     = (bit_cnt_q == '0) && (bus.trans_state == START) && !bus.disconnected_s;
    load_sym_c = bus.sbtx_sel ? crc_slot_sym(crc_c, crc_slot_q) : bus.trans;
    crc_init_c = bus.disconnected_s || (bus.trans_state != START);
    crc_hold_c = (crc_state_q == CRC_HOLD);
    // shift_reg_q[1] is the bit going out this cycle; data bits sit at bit_cnt 1..8.
    crc_bit_c  = shift_reg_q[1];
    crc_upd_c  = (crc_state_q == CRC_ACCUM) && sym_crc_q &&
                 (bit_cnt_q != '0) && (bit_cnt_q <= SB_LAST_DATA_BIT);

    if (bus.disconnected_s) begin
      bit_cnt_d   = '0;
      shift_reg_d = '0;
      sbtx_d      = 1'b0;
      tx_busy_d   = 1'b0;
      crc_slot_d  = 1'b0;
      sym_crc_d   = 1'b0;
      crc_state_d = CRC_INIT;
    end else if (load_c) begin
      shift_reg_d = load_sym_c;
      bit_cnt_d   = SB_CNT_W'(1);
      sbtx_d      = load_sym_c.start;
      tx_busy_d   = 1'b1;
      sym_crc_d   = bus.crc_en && !bus.sbtx_sel;
      if (bus.sbtx_sel) begin
        crc_slot_d  = !crc_slot_q;
        crc_state_d = CRC_HOLD;
      end else if (bus.crc_en && (crc_state_q != CRC_HOLD)) begin
        crc_state_d = CRC_ACCUM;
      end
    end else if (bit_cnt_q != '0) begin
      // In-flight symbol always completes, whatever trans_state does.
      shift_reg_d = shift_reg_q >> 1;
      sbtx_d      = shift_reg_q[1];
      tx_busy_d   = 1'b1;
      bit_cnt_d   = (bit_cnt_q == SB_LAST_BIT) ? '0 : bit_cnt_q + SB_CNT_W'(1);
    end else begin
      tx_busy_d = 1'b0;
      sbtx_d    = (bus.trans_state == IDLE_S);
    end

    if (!bus.disconnected_s && (bus.trans_state != START)) begin
      crc_state_d = CRC_INIT;
      crc_slot_d  = 1'b0;
    end
  end

  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shift_reg_q <= '0;
      sbtx_q      <= 1'b0;
      tx_busy_q   <= 1'b0;
      crc_slot_q  <= 1'b0;
      sym_crc_q   <= 1'b0;
      crc_state_q <= CRC_INIT;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      sbtx_q      <= sbtx_d;
      tx_busy_q   <= tx_busy_d;
      crc_slot_q  <= crc_slot_d;
      sym_crc_q   <= sym_crc_d;
      crc_state_q <= crc_state_d;
    end
  end

  sb_crc16_serial u_crc (
    .clk  (sb_clk),
    .rst  (rst),
    .init (crc_init_c),
    .en   (crc_upd_c),
    .hold (crc_hold_c),
    .d    (crc_bit_c),
    .crc  (crc_c)
  );

  assign bus.sbtx    = sbtx_q;
  assign bus.tx_busy = tx_busy_q;

`ifdef SB_TX_CRC_OUT_EN
  logic [SB_CRC_W-1:0] crc_out_q,   crc_out_d;
  logic                crc_valid_q, crc_valid_d;

  // Capture the final CRC when the first slot is loaded.
  always_comb begin
    crc_valid_d = load_c && bus.sbtx_sel && !crc_slot_q;
    crc_out_d   = crc_valid_d ? crc_c : crc_out_q;
  end

  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_out_q   <= crc_out_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign bus.crc_out   = crc_out_q;
  assign bus.crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Scoreboard bench for sb_tx_serializer: stimulus pushes expected symbols and
// CRCs, a negedge monitor reassembles SBTX symbols and compares.
module tb_sb_tx_serializer;
  import sb_tx_pkg::*;

  logic sb_clk;
  logic rst;

  sb_tx_serializer_if bus();

  sb_tx_serializer dut (
    .sb_clk (sb_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  int          n_cmp;
  int          n_fail;
  logic [9:0]  exp_q[$];
  logic [15:0] crc_exp_q[$];
  bit          expect_abort;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Reference CRC: bytes in order, each byte LSB first, MSB-first poly register.
  function automatic logic [15:0] ref_crc(input logic [7:0] bytes[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = bytes[k][i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic send(input logic [9:0] sym, input bit ce, input bit sel,
                      input logic [9:0] exp, input bit etx);
    bus.trans       = sym;
    bus.crc_en      = ce;
    bus.sbtx_sel    = sel;
    bus.trans_state = START;
    exp_q.push_back(exp);
    @(posedge sb_clk); #1;
    if (etx) bus.trans_state = IDLE_S;
    repeat (9) @(posedge sb_clk);
    #1;
  endtask

  // DLE, payload, two CRC slots, ETX (state drops to idle right after its load).
  task automatic run_txn(input bit rnd, input int npay);
    logic [7:0]  pl[$];
    logic [7:0]  b;
    logic [15:0] c;
    pl = {};
    send(frame(8'hFE), 1'b0, 1'b0, frame(8'hFE), 1'b0);
    for (int i = 0; i < npay; i++) begin
      b = rnd ? 8'($urandom) : 8'h00;
      send(frame(b), 1'b1, 1'b0, frame(b), 1'b0);
      pl.push_back(b);
      if (rnd && ($urandom_range(0, 3) == 0)) begin
        b = 8'($urandom);
        send(frame(b), 1'b0, 1'b0, frame(b), 1'b0);
      end
    end
    c = rnd ? ref_crc(pl) : 16'hFD02;
`ifdef SB_TX_CRC_OUT_EN
    crc_exp_q.push_back(c);
`endif
    b = 8'($urandom);
    send(frame(b), 1'($urandom), 1'b1, frame(c[15:8]), 1'b0);
    b = 8'($urandom);
    send(frame(b), 1'($urandom), 1'b1, frame(c[7:0]), 1'b0);
    send(frame(8'h40), 1'b0, 1'b0, frame(8'h40), 1'b1);
    bus.crc_en   = 1'b0;
    bus.sbtx_sel = 1'b0;
    repeat (3) @(posedge sb_clk);
    #1;
    check("idle_line_after_txn", 32'(bus.sbtx), 32'd1);
    check("idle_busy_after_txn", 32'(bus.tx_busy), 32'd0);
  endtask

  // Monitor: reassemble symbols while tx_busy is high and compare with the queue.
  initial begin
    int         cnt;
    logic [9:0] sh;
    cnt = 0;
    sh  = '0;
    forever begin
      @(negedge sb_clk);
      if (rst) begin
        cnt = 0;
        expect_abort = 1'b0;
      end else begin
`ifdef SB_TX_CRC_OUT_EN
        if (bus.crc_valid) begin
          check("crc_valid_align", 32'(cnt), 32'd0);
          if (crc_exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL crc_valid_unexpected: got crc_out %0h with no pending CRC", bus.crc_out);
          end else begin
            check("crc_out", 32'(bus.crc_out), 32'(crc_exp_q.pop_front()));
          end
        end
`endif
        if (bus.tx_busy) begin
          sh[cnt] = bus.sbtx;
          cnt++;
          if (cnt == 10) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL symbol_unexpected: got %0h with empty queue", sh);
            end else begin
              check("symbol", 32'(sh), 32'(exp_q.pop_front()));
            end
            cnt = 0;
          end
        end else if (cnt != 0) begin
          if (expect_abort) begin
            expect_abort = 1'b0;
          end else begin
            check("partial_symbol_bits", 32'(cnt), 32'd0);
          end
          cnt = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] dle;
    logic [7:0] b;
    n_cmp = 0;
    n_fail = 0;
    expect_abort = 1'b0;
    rst = 1'b1;
    bus.trans = '0;
    bus.trans_state = DISCONNECTED_S;
    bus.crc_en = 1'b0;
    bus.sbtx_sel = 1'b0;
    bus.disconnected_s = 1'b0;

    // Reset and link states
    repeat (2) @(posedge sb_clk);
    #1;
    check("reset_sbtx", 32'(bus.sbtx), 32'd0);
    check("reset_busy", 32'(bus.tx_busy), 32'd0);
`ifdef SB_TX_CRC_OUT_EN
    check("reset_crc_out", 32'(bus.crc_out), 32'd0);
    check("reset_crc_valid", 32'(bus.crc_valid), 32'd0);
`endif
    rst = 1'b0;
    @(posedge sb_clk); #1;
    check("disc_line", 32'(bus.sbtx), 32'd0);
    bus.trans_state = IDLE_S;
    @(posedge sb_clk); #1;
    check("idle_line", 32'(bus.sbtx), 32'd1);

    // Single DLE with per-cycle bit and busy checks
    dle = frame(8'hFE);
    bus.trans = dle;
    bus.trans_state = START;
    exp_q.push_back(dle);
    for (int i = 0; i < 10; i++) begin
      @(posedge sb_clk); #1;
      check("dle_bit", 32'(bus.sbtx), 32'(dle[i]));
      check("dle_busy", 32'(bus.tx_busy), 32'd1);
      if (i == 9) bus.trans_state = IDLE_S;
    end
    @(posedge sb_clk); #1;
    check("dle_busy_end", 32'(bus.tx_busy), 32'd0);
    check("dle_idle_after", 32'(bus.sbtx), 32'd1);

    // Directed CRC scenario twice with an idle gap
    run_txn(1'b0, 1);
    run_txn(1'b0, 1);

    // Disconnect wins over a would-be load
    bus.disconnected_s = 1'b1;
    bus.trans = frame(8'hFE);
    bus.trans_state = START;
    repeat (3) begin
      @(posedge sb_clk); #1;
      check("disc_no_load_busy", 32'(bus.tx_busy), 32'd0);
      check("disc_no_load_line", 32'(bus.sbtx), 32'd0);
    end
    bus.disconnected_s = 1'b0;
    bus.trans_state = IDLE_S;
    @(posedge sb_clk); #1;
    check("idle_after_disc", 32'(bus.sbtx), 32'd1);

    // Abort at bit_cnt=5 of a payload symbol
    send(frame(8'hFE), 1'b0, 1'b0, frame(8'hFE), 1'b0);
    b = 8'($urandom);
    bus.trans = frame(b);
    bus.crc_en = 1'b1;
    bus.sbtx_sel = 1'b0;
    bus.trans_state = START;
    @(posedge sb_clk); #1;
    repeat (4) @(posedge sb_clk);
    #1;
    expect_abort = 1'b1;
    bus.disconnected_s = 1'b1;
    @(posedge sb_clk); #1;
    check("abort_sbtx", 32'(bus.sbtx), 32'd0);
    check("abort_busy", 32'(bus.tx_busy), 32'd0);
    bus.trans_state = DISCONNECTED_S;
    @(posedge sb_clk); #1;
    check("abort_hold_sbtx", 32'(bus.sbtx), 32'd0);
    bus.disconnected_s = 1'b0;
    bus.crc_en = 1'b0;
    bus.trans_state = IDLE_S;
    @(posedge sb_clk); #1;
    check("idle_after_abort", 32'(bus.sbtx), 32'd1);
    run_txn(1'b1, 2);

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      run_txn(1'b1, $urandom_range(1, 6));
    end

    // Async reset while the first CRC slot is shifting
    send(frame(8'hFE), 1'b0, 1'b0, frame(8'hFE), 1'b0);
    send(frame(8'h00), 1'b1, 1'b0, frame(8'h00), 1'b0);
`ifdef SB_TX_CRC_OUT_EN
    crc_exp_q.push_back(16'hFD02);
`endif
    bus.trans = frame(8'h5A);
    bus.crc_en = 1'b0;
    bus.sbtx_sel = 1'b1;
    @(posedge sb_clk); #1;
    repeat (3) @(posedge sb_clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_sbtx", 32'(bus.sbtx), 32'd0);
    check("async_rst_busy", 32'(bus.tx_busy), 32'd0);
`ifdef SB_TX_CRC_OUT_EN
    check("async_rst_crc_out", 32'(bus.crc_out), 32'd0);
    check("async_rst_crc_valid", 32'(bus.crc_valid), 32'd0);
`endif
    bus.sbtx_sel = 1'b0;
    bus.trans_state = IDLE_S;
    @(posedge sb_clk); #1;
    rst = 1'b0;
    @(posedge sb_clk); #1;
    check("idle_after_rst", 32'(bus.sbtx), 32'd1);
    run_txn(1'b1, 3);

    repeat (20) @(posedge sb_clk);
    #1;
    check("sym_queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef SB_TX_CRC_OUT_EN
    check("crc_queue_drained", 32'(crc_exp_q.size()), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
